fp_writeback_unit: RTL

Writeback side of the floating-point register file. Accepts results from the multi-cycle FPU (valid/ready) and from the load/store unit (valid only, highest priority), serialises them onto the single register-file write port, and keeps a per-register busy scoreboard so issue logic can detect RAW/WAW hazards on the three FP read operands. Also accumulates the sticky IEEE exception flags (fflags) of retired FPU results.

---
 rtl/fp_writeback_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fp_writeback_unit.sv
// FP register-file writeback: FPU result queue, LSU priority port, busy scoreboard
// and sticky fflags accumulation.
module fp_writeback_unit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fpu_valid_i,
  output logic        fpu_ready_o,
  input  logic [4:0]  fpu_rd_i,
  input  logic [31:0] fpu_result_i,
  input  logic [4:0]  fpu_fflags_i,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  input  logic        alloc_i,
  input  logic [4:0]  alloc_rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rs3_i,
  input  logic [4:0]  rd_i,
  output logic        hazard_o,
  output logic        fregwrite_o,
  output logic [4:0]  frd_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  fflags_o,
  input  logic        fflags_clr_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [4:0]       q_rd_q   [DEPTH];
  logic [31:0]      q_data_q [DEPTH];
  logic [4:0]       q_flg_q  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        fregwrite_q, fregwrite_d;
  logic [4:0]  frd_q, frd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  fflags_q, fflags_d;
  logic [31:0] busy_q, busy_d;

  logic push, pop;

  assign fpu_ready_o = (count_q != CNT_W'(DEPTH));
  assign push        = fpu_valid_i & fpu_ready_o;
  // Loads always win the write port; the queue only drains on LSU-idle cycles.
  assign pop         = ~lsu_valid_i & (count_q != '0);

  // Queue storage needs no reset: validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_rd_q[wr_ptr_q]   <= fpu_rd_i;
      q_data_q[wr_ptr_q] <= fpu_result_i;
      q_flg_q[wr_ptr_q]  <= fpu_fflags_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    fregwrite_d = 1'b0;
    frd_d       = frd_q;
    wb_data_d   = wb_data_q;
    fflags_d    = fflags_q;
    if (lsu_valid_i) begin
      fregwrite_d = 1'b1;
      frd_d       = lsu_rd_i;
      wb_data_d   = lsu_data_i;
    end else if (pop) begin
      fregwrite_d = 1'b1;
      frd_d       = q_rd_q[rd_ptr_q];
      wb_data_d   = q_data_q[rd_ptr_q];
    end
    if (pop) begin
      fflags_d = fflags_clr_i ? q_flg_q[rd_ptr_q] : (fflags_q | q_flg_q[rd_ptr_q]);
    end else if (fflags_clr_i) begin
      fflags_d = '0;
    end
  end

  // Clear first so a same-cycle allocation of the retiring register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (fregwrite_q) busy_d[frd_q] = 1'b0;
    if (alloc_i)     busy_d[alloc_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fregwrite_q <= 1'b0;
      frd_q       <= '0;
      wb_data_q   <= '0;
      fflags_q    <= '0;
      busy_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fregwrite_q <= fregwrite_d;
      frd_q       <= frd_d;
      wb_data_q   <= wb_data_d;
      fflags_q    <= fflags_d;
      busy_q      <= busy_d;
    end
  end

  assign fregwrite_o = fregwrite_q;
  assign frd_o       = frd_q;
  assign wb_data_o   = wb_data_q;
  assign fflags_o    = fflags_q;
  assign hazard_o    = busy_q[rs1_i] | busy_q[rs2_i] | busy_q[rs3_i] | busy_q[rd_i];

endmodule
